seg_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment display driver. The block samples the scanned `com`/`seg`/`dot` lines and debounces each digit dwell. It decodes the segment patterns back to BCD and rebuilds the six-digit HH:MM:SS time bus. It sits on the display outputs of the nap machine and is used for on-board self-check, readback to the time_register compare path, and bench observation without tapping internal nets.

---
 rtl/seg_scan_decoder_if.sv | 28 ++
 rtl/seg_scan_decoder.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_decoder_if                                                   |
// | Scanned display lines in, rebuilt time bus and status out.            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface seg_scan_decoder_if;
  logic [7:0]  com;
  logic [6:0]  seg;
  logic        dot;
  logic [23:0] time_out;
  logic [5:0]  blank_mask;
  logic [5:0]  dot_mask;
  logic [5:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  modport master (
    output com, seg, dot,
    input  time_out, blank_mask, dot_mask, digit_err, frame_valid, stale
  );

  modport slave (
    input  com, seg, dot,
    output time_out, blank_mask, dot_mask, digit_err, frame_valid, stale
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_decoder                                                      |
// | Debounces scanned 7-segment dwells and rebuilds the HH:MM:SS BCD bus. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  seg_scan_decoder_if.slave  bus
);

  localparam logic [7:0]  c_SETTLE     = 8'(SETTLE);
  localparam logic [7:0]  c_SETTLE_M1  = 8'(SETTLE - 1);
  localparam logic [23:0] c_TIMEOUT    = 24'(TIMEOUT);

  logic [7:0]       r_com_s;
  logic [6:0]       r_seg_s;
  logic             r_dot_s;
  logic [7:0]       r_dwell;
  logic             r_done;
  logic [23:0]      r_timer;
  logic [5:0]       r_seen;
  logic [5:0][3:0]  r_nib;
  logic [5:0]       r_blank_sh;
  logic [5:0]       r_err_sh;
  logic [5:0]       r_dot_sh;
  logic [23:0]      r_time;
  logic [5:0]       r_blank;
  logic [5:0]       r_dot;
  logic [5:0]       r_err;
  logic             r_fv;
  logic             r_stale;

  logic [5:0]       w_sel;
  logic             w_onehot;
  logic             w_same;
  logic             w_stable;
  logic             w_capture;
  logic             w_commit;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic             w_err;
  logic [5:0][3:0]  w_nib_m;
  logic [5:0]       w_blank_m;
  logic [5:0]       w_err_m;
  logic [5:0]       w_dot_m;
  logic [23:0]      w_time;

  assign w_sel     = ~bus.com[5:0];
  assign w_onehot  = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);
  assign w_same    = ({bus.com, bus.seg, bus.dot} == {r_com_s, r_seg_s, r_dot_s});
  assign w_stable  = w_same && w_onehot;
  // Capture on the edge that would bring the dwell count up to SETTLE.
  assign w_capture = w_stable && !r_done && (r_dwell == c_SETTLE_M1);
  assign w_commit  = w_capture && ((r_seen | w_sel) == 6'h3F);

  always_comb begin
    w_nib   = 4'hF;
    w_blank = 1'b0;
    w_err   = 1'b0;
    case (bus.seg)
      7'b1111110: w_nib = 4'd0;
      7'b0110000: w_nib = 4'd1;
      7'b1101101: w_nib = 4'd2;
      7'b1111001: w_nib = 4'd3;
      7'b0110011: w_nib = 4'd4;
      7'b1011011: w_nib = 4'd5;
      7'b1011111: w_nib = 4'd6;
      7'b1110000: w_nib = 4'd7;
      7'b1111111: w_nib = 4'd8;
      7'b1111011: w_nib = 4'd9;
      7'b0000000: w_blank = 1'b1;
      default:    w_err = 1'b1;
    endcase
  end

  // Shadow contents with the current capture merged in, so a commit sees the sixth digit.
  generate
    for (genvar k = 0; k < 6; k++) begin : g_slot
      assign w_nib_m[k] = (w_capture && w_sel[k]) ? w_nib : r_nib[k];
      assign w_time[23 - 4*k -: 4] = w_nib_m[k];
    end
  endgenerate

  assign w_blank_m = w_capture ? ((r_blank_sh & ~w_sel) | (w_blank ? w_sel : 6'd0)) : r_blank_sh;
  assign w_err_m   = w_capture ? ((r_err_sh & ~w_sel) | (w_err ? w_sel : 6'd0)) : r_err_sh;
  assign w_dot_m   = w_capture ? ((r_dot_sh & ~w_sel) | (bus.dot ? w_sel : 6'd0)) : r_dot_sh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_com_s    <= 8'd0;
      r_seg_s    <= 7'd0;
      r_dot_s    <= 1'b0;
      r_dwell    <= 8'd0;
      r_done     <= 1'b0;
      r_timer    <= 24'd0;
      r_seen     <= 6'd0;
      r_nib      <= '0;
      r_blank_sh <= 6'd0;
      r_err_sh   <= 6'd0;
      r_dot_sh   <= 6'd0;
      r_time     <= 24'hFFFFFF;
      r_blank    <= 6'd0;
      r_dot      <= 6'd0;
      r_err      <= 6'd0;
      r_fv       <= 1'b0;
      r_stale    <= 1'b1;
    end else begin
      r_com_s <= bus.com;
      r_seg_s <= bus.seg;
      r_dot_s <= bus.dot;

      if (!w_stable) begin
        r_dwell <= 8'd0;
        r_done  <= 1'b0;
      end else begin
        if (r_dwell != c_SETTLE) r_dwell <= r_dwell + 8'd1;
        if (w_capture) r_done <= 1'b1;
      end

      r_nib      <= w_nib_m;
      r_blank_sh <= w_blank_m;
      r_err_sh   <= w_err_m;
      r_dot_sh   <= w_dot_m;

      if (w_commit) r_seen <= 6'd0;
      else if (w_capture) r_seen <= r_seen | w_sel;

      r_fv <= w_commit;
      if (w_commit) begin
        r_time  <= w_time;
        r_blank <= w_blank_m;
        r_dot   <= w_dot_m;
        r_err   <= w_err_m;
      end

      // Commit beats timeout when both land on the same edge.
      if (w_commit) begin
        r_timer <= 24'd0;
        r_stale <= 1'b0;
      end else if (r_timer != c_TIMEOUT) begin
        r_timer <= r_timer + 24'd1;
        if ((r_timer + 24'd1) == c_TIMEOUT) r_stale <= 1'b1;
      end
    end
  end

  assign bus.time_out    = r_time;
  assign bus.blank_mask  = r_blank;
  assign bus.dot_mask    = r_dot;
  assign bus.digit_err   = r_err;
  assign bus.frame_valid = r_fv;
  assign bus.stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_decoder                                                   |
// | Table-driven frames with a scoreboard, plus hand-written corner cases.|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seg_scan_decoder;

  localparam logic [6:0] c_ERRP = 7'b1000000;

  typedef struct packed {
    logic [23:0] t;
    logic [5:0]  b;
    logic [5:0]  d;
    logic [5:0]  e;
  } exp_t;

  typedef struct {
    logic [41:0] segs;
    logic [5:0]  dots;
    exp_t        exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(.SETTLE(4), .TIMEOUT(50)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [41:0] pat6(input logic [6:0] p0, p1, p2, p3, p4, p5);
    return {p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic drive(input logic [7:0] c, input logic [6:0] s, input logic d, input int n);
    bus.com = c;
    bus.seg = s;
    bus.dot = d;
    repeat (n) @(negedge clock);
  endtask

  task automatic show(input int k, input logic [6:0] s, input logic d, input int n);
    logic [7:0] c;
    c = 8'hFF;
    c[k] = 1'b0;
    drive(c, s, d, n);
  endtask

  task automatic scan(input logic [41:0] segs, input logic [5:0] dots, input int n);
    for (int k = 0; k < 6; k++) show(k, segs[k*7 +: 7], dots[k], n);
  endtask

  // Scoreboard consumer: every frame pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (reset && bus.frame_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got time %0h expected no frame at %0t", bus.time_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_time",  32'(bus.time_out),   32'(e.t));
        chk("frame_blank", 32'(bus.blank_mask), 32'(e.b));
        chk("frame_dot",   32'(bus.dot_mask),   32'(e.d));
        chk("frame_err",   32'(bus.digit_err),  32'(e.e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic got;

    vecs[0].segs = pat6(seg_of(1), seg_of(2), seg_of(3), seg_of(4), seg_of(5), seg_of(6));
    vecs[0].dots = 6'b000000;
    vecs[0].exp  = '{t: 24'h123456, b: 6'b000000, d: 6'b000000, e: 6'b000000};
    vecs[1].segs = pat6(7'b0, 7'b0, seg_of(5), c_ERRP, seg_of(3), seg_of(7));
    vecs[1].dots = 6'b000000;
    vecs[1].exp  = '{t: 24'hFF5F37, b: 6'b000011, d: 6'b000000, e: 6'b001000};
    vecs[2].segs = pat6(seg_of(0), seg_of(9), seg_of(4), seg_of(1), seg_of(2), seg_of(8));
    vecs[2].dots = 6'b001010;
    vecs[2].exp  = '{t: 24'h094128, b: 6'b000000, d: 6'b001010, e: 6'b000000};
    vecs[3].segs = pat6(seg_of(8), seg_of(7), seg_of(6), seg_of(5), seg_of(9), seg_of(0));
    vecs[3].dots = 6'b100001;
    vecs[3].exp  = '{t: 24'h876590, b: 6'b000000, d: 6'b100001, e: 6'b000000};

    reset = 1'b0;
    bus.com = 8'hFF;
    bus.seg = 7'd0;
    bus.dot = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_time",  32'(bus.time_out),    32'hFFFFFF);
    chk("rst_blank", 32'(bus.blank_mask),  32'h0);
    chk("rst_dot",   32'(bus.dot_mask),    32'h0);
    chk("rst_err",   32'(bus.digit_err),   32'h0);
    chk("rst_fv",    32'(bus.frame_valid), 32'h0);
    chk("rst_stale", 32'(bus.stale),       32'h1);
    reset = 1'b1;

    // Dwells of exactly SETTLE edges never capture.
    repeat (3) scan(vecs[0].segs, 6'b0, 4);
    chk("short_stale", 32'(bus.stale),    32'h1);
    chk("short_time",  32'(bus.time_out), 32'hFFFFFF);

    foreach (vecs[i]) begin
      sb.push_back(vecs[i].exp);
      scan(vecs[i].segs, vecs[i].dots, 10);
      chk("vec_drained", 32'(sb.size()), 32'h0);
      chk("vec_stale",   32'(bus.stale),  32'h0);
    end

    // Glitch splitting a dwell of a new value on digit 2 must keep the older capture.
    sb.push_back('{t: 24'h097128, b: 6'b0, d: 6'b001010, e: 6'b0});
    show(0, seg_of(0), 1'b0, 10);
    show(1, seg_of(9), 1'b1, 10);
    show(2, seg_of(7), 1'b0, 10);
    show(2, seg_of(4), 1'b0, 4);
    drive(8'hFF, seg_of(4), 1'b0, 1);
    show(2, seg_of(4), 1'b0, 4);
    show(3, seg_of(1), 1'b1, 10);
    show(4, seg_of(2), 1'b0, 10);
    show(5, seg_of(8), 1'b0, 10);
    chk("glitchA_drained", 32'(sb.size()), 32'h0);

    // Glitch mid-dwell followed by a long enough re-settle captures the digit.
    sb.push_back('{t: 24'h094128, b: 6'b0, d: 6'b001010, e: 6'b0});
    show(0, seg_of(0), 1'b0, 10);
    show(1, seg_of(9), 1'b1, 10);
    show(2, seg_of(4), 1'b0, 3);
    drive(8'hFF, seg_of(4), 1'b0, 1);
    show(2, seg_of(4), 1'b0, 8);
    show(3, seg_of(1), 1'b1, 10);
    show(4, seg_of(2), 1'b0, 10);
    show(5, seg_of(8), 1'b0, 10);
    chk("glitchB_drained", 32'(sb.size()), 32'h0);

    // Reset mid-frame discards the four partial captures.
    for (int k = 0; k < 4; k++) show(k, seg_of(1), 1'b0, 10);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_time",  32'(bus.time_out),   32'hFFFFFF);
    chk("mid_rst_dot",   32'(bus.dot_mask),   32'h0);
    chk("mid_rst_stale", 32'(bus.stale),      32'h1);
    @(negedge clock);
    reset = 1'b1;
    sb.push_back('{t: 24'h235959, b: 6'b0, d: 6'b0, e: 6'b0});
    show(4, seg_of(5), 1'b0, 10);
    show(5, seg_of(9), 1'b0, 10);
    chk("post_rst_no_frame", 32'(sb.size()), 32'h1);
    show(0, seg_of(2), 1'b0, 10);
    show(1, seg_of(3), 1'b0, 10);
    show(2, seg_of(5), 1'b0, 10);
    show(3, seg_of(9), 1'b0, 10);
    chk("post_rst_drained", 32'(sb.size()), 32'h0);

    // Stale rises exactly TIMEOUT cycles after the commit edge.
    sb.push_back('{t: 24'h000000, b: 6'b0, d: 6'b0, e: 6'b0});
    for (int k = 0; k < 5; k++) show(k, seg_of(0), 1'b0, 10);
    show(5, seg_of(0), 1'b0, 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (bus.frame_valid) got = 1'b1;
    end
    chk("to_commit_seen", 32'(got), 32'h1);
    bus.com = 8'hFF;
    chk("to_stale_k0", 32'(bus.stale), 32'h0);
    repeat (49) @(negedge clock);
    chk("to_stale_k49", 32'(bus.stale), 32'h0);
    @(negedge clock);
    chk("to_stale_k50", 32'(bus.stale),    32'h1);
    chk("to_time_kept", 32'(bus.time_out), 32'h000000);
    sb.push_back(vecs[0].exp);
    scan(vecs[0].segs, vecs[0].dots, 10);
    chk("to_recover_stale",   32'(bus.stale),  32'h0);
    chk("to_recover_drained", 32'(sb.size()),  32'h0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
